// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per power-of-two shift level,
// with a combinational ready chain so a full pipeline keeps one beat per cycle.
`timescale 1ns/1ps

module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   valid_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   amt_d  [SHW];
  logic [1:0]       op_q   [SHW];
  logic [1:0]       op_d   [SHW];
  logic [SHW:0]     advance;

  // Arithmetic right replicates the current MSB, which after every earlier
  // level is still the operand's original sign bit.
  function automatic logic [WIDTH-1:0] levelShift(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] op,
                                                  input int unsigned s);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    dbl = {d, d};
    r   = d;
    case (op)
      2'b00: begin
        dbl = dbl >> s;
        r   = dbl[WIDTH-1:0];
      end
      2'b01: begin
        dbl = dbl << s;
        r   = dbl[2*WIDTH-1:WIDTH];
      end
      2'b10:   r = d >> s;
      default: r = $signed(d) >>> s;
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < SHW; k++) begin : gStage
    localparam int unsigned Shift = 1 << k;
    logic [WIDTH-1:0] srcData;
    logic [SHW-1:0]   srcAmt;
    logic [1:0]       srcOp;
    logic             srcValid;

    if (k == 0) begin : gHead
      assign srcData  = in_data;
      assign srcAmt   = in_amt;
      assign srcOp    = in_op;
      assign srcValid = in_valid;
    end else begin : gBody
      assign srcData  = data_q[k-1];
      assign srcAmt   = amt_q[k-1];
      assign srcOp    = op_q[k-1];
      assign srcValid = valid_q[k-1];
    end

    assign data_d[k]  = srcAmt[k] ? levelShift(srcData, srcOp, Shift) : srcData;
    assign amt_d[k]   = srcAmt;
    assign op_d[k]    = srcOp;
    assign valid_d[k] = srcValid;
  end

  // A stage may load when it is empty or its own contents move on this edge.
  always_comb begin
    advance      = '0;
    advance[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      advance[k] = !valid_q[k] || advance[k+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (advance[k]) begin
          valid_q[k] <= valid_d[k];
          data_q[k]  <= data_d[k];
          amt_q[k]   <= amt_d[k];
          op_q[k]    <= op_d[k];
        end
      end
    end
  end

  assign in_ready  = advance[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for WIDTH-bit data. Supports rotate right, rotate left, logical right shift and arithmetic right shift, with a run-time shift amount. Uses one register stage per shift level (log2(WIDTH) stages) and valid/ready handshakes on both sides, so it drops into streaming datapaths at full throughput with backpressure.

Parameters:
WIDTH, 8, data width in bits; must be a power of 2 and at least 2
SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, must not be overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts the input beat this cycle
in_data  input  WIDTH  operand
in_amt  input  SHW  shift amount, 0..WIDTH-1
in_op  input  2  00 rotate right, 01 rotate left, 10 logical right, 11 arithmetic right
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts the result beat
out_data  output  WIDTH  shifted result

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst is high, all stage valids are 0 and all stage data/amount/op registers are 0, so out_valid=0 and out_data=0. The first accept is possible on the first rising edge after rst deasserts.
- Pipeline: stage k (k=0..SHW-1) registers data, op, amount and valid. Stage 0 captures the input, applying level 0 on the way in.
- Level k shifts by 2^k if amt[k]=1; otherwise it passes the data unchanged.
- The output is the last-stage register, with no combinational path from in_data to out_data.
- Latency: exactly SHW cycles from accept to out_valid when there are no stalls (3 for WIDTH=8).
- Handshakes:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready.
- Stage k advances when its successor is empty or its successor advances. The last stage advances when it is empty or out_ready=1.
- in_ready = !stage0_valid || stage0 advances. The ready chain is combinational, with no bubbles.
- Throughput: 1 beat/cycle when out_ready is held high.
- Stall: a stalled stage holds data, op, amount and valid stable. out_data and out_valid stay stable while out_valid && !out_ready (AXI-style rule).
- in_valid must not depend on in_ready.
- Level operation at shift s = 2^k:
  - Rotate right: d[i] <= d[(i+s) mod WIDTH].
  - Rotate left: d[i] <= d[(i-s) mod WIDTH].
  - Logical right: upper s bits become 0.
  - Arithmetic right: upper s bits are filled with the original MSB, carried through the stages as the op-captured sign. Equivalently, each level replicates the current MSB.
- in_amt=0 returns in_data unchanged in every mode. Amounts are always less than WIDTH by construction, so there is no overshift case.
- A stage that is not valid may hold stale data. Its contents must never reach out_data with out_valid=1.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops asynchronously. No partial result is emitted after release.
- Ordering: results leave in acceptance order. There is no reordering and no dropping while rst=0.

Test Plan:
- Reset, then drive WIDTH=8, in_data=8'h81, amt=1, op=00 with out_ready=1 -> out_data=8'hC0, out_valid=1 exactly 3 cycles after accept, for one cycle.
- Back-to-back beats with out_ready=1: (8'h81, amt 3, op 01), (8'h80, amt 7, op 10), (8'h80, amt 3, op 11), (8'h5A, amt 0, op 00) -> outputs 8'h0C, 8'h01, 8'hF0, 8'h5A on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: fill the pipeline with 4 beats while out_ready=0 -> out_valid=1 with out_data frozen, in_ready=0 once all stages are full, and no beat is lost. Then release out_ready -> results in order, 1 per cycle.
- Random out_ready toggling with 1000 random beats across all ops and amounts -> scoreboard against a reference model with zero mismatches and no duplicates.
- Assert rst asynchronously (between edges) with 3 beats in flight -> out_valid=0 and out_data=0 immediately. After release, no stale beat appears and the first new beat emerges 3 cycles after accept.
- Parameter sweep WIDTH=2, 16, 32: for WIDTH=32, op=11, in_data=32'h8000_0000, amt=31 -> out_data=32'hFFFF_FFFF after 5 cycles.
